mult_fu: RTL and testbench
==========================

MULT_FU -- requirements
Module: mult_fu

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, meaning pipeline depth; legal values 2, 4, 8.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous squash of all in-flight operations (branch mispredict).
REQ-005 SHALL have port rs_valid_in  input  1  the RS is issuing a multiply this cycle.
REQ-006 SHALL have ports rs_opa_in and rs_opb_in  input  64 each  source operands.
REQ-007 SHALL have port rs_dest_tag_in  input  $clog2(`PRF_SIZE)  destination PRF tag.
REQ-008 SHALL have port rs_rob_idx_in  input  $clog2(`ROB_SIZE)  ROB index.
REQ-009 SHALL have port cdb_grant_in  input  1  CDB arbiter accepts this unit's result this cycle.
REQ-010 SHALL have port mult_available  output  1  unit accepts an issue this cycle; drives the RS fuN_mult_available input.
REQ-011 SHALL have port result_out  output  64  product.
REQ-012 SHALL have port result_tag_out  output  $clog2(`PRF_SIZE)  destination tag for CDB.
REQ-013 SHALL have port result_rob_idx_out  output  $clog2(`ROB_SIZE)  ROB index for CDB.
REQ-014 SHALL have port result_valid_out  output  1  result request toward the CDB arbiter.

Function
REQ-015 SHALL compute the MULQ result: low 64 bits of rs_opa_in * rs_opb_in, two's-complement wraparound, no overflow flag.
REQ-016 SHALL implement NUM_STAGES registered stages, each holding a valid bit, tag, ROB index, operands and a partial product.
REQ-017 SHALL accumulate 64/NUM_STAGES multiplier bits per stage, LSB chunk first; stage NUM_STAGES holds the final product and drives the result_* outputs directly.
REQ-018 SHALL accept an issue on a rising edge where rs_valid_in=1, mult_available=1 and flush=0; the operation loads into stage 1.
REQ-019 SHALL ignore rs_valid_in when mult_available=0, with no state change.
REQ-020 SHALL, absent stall, raise result_valid_out after the NUM_STAGES-th rising edge, counting the acceptance edge as the first (default: 3 cycles after the acceptance cycle).
REQ-021 SHALL retire the stage-NUM_STAGES entry on an edge where result_valid_out=1 and cdb_grant_in=1.
REQ-022 SHALL hold result_* stable while result_valid_out=1 and cdb_grant_in=0.
REQ-023 SHALL advance stage k when stage k+1 is empty or advancing on the same edge, so bubbles collapse; the stage-NUM_STAGES entry advances only on retire.
REQ-024 SHALL drive mult_available combinationally as (stage 1 empty) OR (stage 1 advancing).
REQ-025 SHALL sustain one accept and one retire per cycle with cdb_grant_in held high.
REQ-026 SHALL drive result_out, result_tag_out and result_rob_idx_out to 0 whenever result_valid_out=0.
REQ-027 SHALL, on an edge with flush=1, clear every stage valid bit and drop any issue presented that cycle; result_valid_out=0 and mult_available=1 in the following cycle.
REQ-028 SHALL give flush priority over both a grant and an issue in the same cycle.

Reset
REQ-029 SHALL, while reset=1, clear all valid bits and all data registers to 0 immediately, without waiting for a clock edge.
REQ-030 SHALL output result_valid_out=0, result_*=0 and mult_available=1 while reset is asserted and after it is released.
REQ-031 SHALL discard in-flight operations when reset asserts mid-operation; none reappears after reset release.

Verification
REQ-032 Single op: issue opa=32, opb=26, tag=1, rob=0 with grant=1 -> result_valid_out=1 three cycles later, result_out=0x340, tag=1, rob=0, then 0 the next cycle.
REQ-033 Wraparound: opa=0xFFFF_FFFF_FFFF_FFFF, opb=2 -> result_out=0xFFFF_FFFF_FFFF_FFFE; opa=0x1_0000_0000, opb=0x1_0000_0000 -> result_out=0.
REQ-034 Back-to-back: issue 5 ops on consecutive cycles with grant=1 -> 5 consecutive valid results in issue order; mult_available stays 1.
REQ-035 Stall: grant=0 while issuing continuously -> mult_available falls after exactly NUM_STAGES accepts; output held stable; raising grant drains the ops in order with no loss or duplicate.
REQ-036 Flush: issue 3 ops, then assert flush together with a new issue and grant=1 -> no result appears in any later cycle, and mult_available=1 in the cycle after the flush.
REQ-037 Reset mid-op: pulse reset between clock edges with 2 ops in flight -> outputs go to 0 at once; no result after reset release; the first op issued afterwards completes with normal latency.

Source files
------------

// File: rtl/mult_fu.sv
// mult_fu: pipelined 64x64 MULQ unit. Each stage folds 64/NUM_STAGES multiplier bits
// into the partial product; the last stage presents the result to the CDB.
`ifndef PRF_SIZE
`define PRF_SIZE 64
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif

module mult_fu #(
   parameter int NUM_STAGES = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          rs_valid_in,
   input  logic [63:0]                   rs_opa_in,
   input  logic [63:0]                   rs_opb_in,
   input  logic [$clog2(`PRF_SIZE)-1:0]  rs_dest_tag_in,
   input  logic [$clog2(`ROB_SIZE)-1:0]  rs_rob_idx_in,
   input  logic                          cdb_grant_in,
   output logic                          mult_available,
   output logic [63:0]                   result_out,
   output logic [$clog2(`PRF_SIZE)-1:0]  result_tag_out,
   output logic [$clog2(`ROB_SIZE)-1:0]  result_rob_idx_out,
   output logic                          result_valid_out
);

   localparam int TAG_W   = $clog2(`PRF_SIZE);
   localparam int ROB_W   = $clog2(`ROB_SIZE);
   localparam int CHUNK_W = 64 / NUM_STAGES;

   logic              valid_r [NUM_STAGES];
   logic [TAG_W-1:0]  tag_r   [NUM_STAGES];
   logic [ROB_W-1:0]  rob_r   [NUM_STAGES];
   logic [63:0]       opa_r   [NUM_STAGES];
   logic [63:0]       opb_r   [NUM_STAGES];
   logic [63:0]       prod_r  [NUM_STAGES];

   logic [NUM_STAGES-1:0] move_s;
   logic                  accept_s;

   // Contribution of multiplier chunk idx, already shifted into place (low 64 bits only).
   function automatic logic [63:0] chunk_term(input logic [63:0] opa,
                                              input logic [63:0] opb,
                                              input int          idx);
      logic [63:0] chunk;
      chunk = (opb >> (idx * CHUNK_W)) & {{(64-CHUNK_W){1'b0}}, {CHUNK_W{1'b1}}};
      return (opa * chunk) << (idx * CHUNK_W);
   endfunction

   // Hand-off chain: the last stage leaves on grant, earlier stages leave when the next one frees up.
   always_comb begin
      move_s = {NUM_STAGES{1'b0}};
      move_s[NUM_STAGES-1] = valid_r[NUM_STAGES-1] & cdb_grant_in;
      for (int k = NUM_STAGES - 2; k >= 0; k--) begin
         move_s[k] = valid_r[k] & (~valid_r[k+1] | move_s[k+1]);
      end
   end

   assign mult_available = ~valid_r[0] | move_s[0];
   assign accept_s       = rs_valid_in & mult_available & ~flush;

   // Stage registers; a stage that empties is zeroed so the outputs read 0 when idle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            valid_r[k] <= 1'b0;
            tag_r[k]   <= {TAG_W{1'b0}};
            rob_r[k]   <= {ROB_W{1'b0}};
            opa_r[k]   <= 64'd0;
            opb_r[k]   <= 64'd0;
            prod_r[k]  <= 64'd0;
         end
      end else if (flush) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            valid_r[k] <= 1'b0;
            tag_r[k]   <= {TAG_W{1'b0}};
            rob_r[k]   <= {ROB_W{1'b0}};
            opa_r[k]   <= 64'd0;
            opb_r[k]   <= 64'd0;
            prod_r[k]  <= 64'd0;
         end
      end else begin
         if (accept_s) begin
            valid_r[0] <= 1'b1;
            tag_r[0]   <= rs_dest_tag_in;
            rob_r[0]   <= rs_rob_idx_in;
            opa_r[0]   <= rs_opa_in;
            opb_r[0]   <= rs_opb_in;
            prod_r[0]  <= chunk_term(rs_opa_in, rs_opb_in, 32'sd0);
         end else if (move_s[0]) begin
            valid_r[0] <= 1'b0;
            tag_r[0]   <= {TAG_W{1'b0}};
            rob_r[0]   <= {ROB_W{1'b0}};
            opa_r[0]   <= 64'd0;
            opb_r[0]   <= 64'd0;
            prod_r[0]  <= 64'd0;
         end else begin
            valid_r[0] <= valid_r[0];
         end
         for (int k = 1; k < NUM_STAGES; k++) begin
            if (move_s[k-1]) begin
               valid_r[k] <= 1'b1;
               tag_r[k]   <= tag_r[k-1];
               rob_r[k]   <= rob_r[k-1];
               opa_r[k]   <= opa_r[k-1];
               opb_r[k]   <= opb_r[k-1];
               prod_r[k]  <= prod_r[k-1] + chunk_term(opa_r[k-1], opb_r[k-1], k);
            end else if (move_s[k]) begin
               valid_r[k] <= 1'b0;
               tag_r[k]   <= {TAG_W{1'b0}};
               rob_r[k]   <= {ROB_W{1'b0}};
               opa_r[k]   <= 64'd0;
               opb_r[k]   <= 64'd0;
               prod_r[k]  <= 64'd0;
            end else begin
               valid_r[k] <= valid_r[k];
            end
         end
      end
   end

   assign result_valid_out   = valid_r[NUM_STAGES-1];
   assign result_out         = prod_r[NUM_STAGES-1];
   assign result_tag_out     = tag_r[NUM_STAGES-1];
   assign result_rob_idx_out = rob_r[NUM_STAGES-1];

endmodule

// File: tb/tb_mult_fu.sv
// tb_mult_fu: directed and randomized checks of mult_fu against an op-queue reference model.
`ifndef PRF_SIZE
`define PRF_SIZE 64
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif

module tb_mult_fu;
   localparam int N     = 4;
   localparam int TAG_W = $clog2(`PRF_SIZE);
   localparam int ROB_W = $clog2(`ROB_SIZE);

   logic              clock = 1'b0;
   logic              reset, flush, rs_valid_in, cdb_grant_in;
   logic [63:0]       rs_opa_in, rs_opb_in;
   logic [TAG_W-1:0]  rs_dest_tag_in;
   logic [ROB_W-1:0]  rs_rob_idx_in;
   logic              mult_available, result_valid_out;
   logic [63:0]       result_out;
   logic [TAG_W-1:0]  result_tag_out;
   logic [ROB_W-1:0]  result_rob_idx_out;

   mult_fu #(.NUM_STAGES(N)) dut (
      .clock(clock), .reset(reset), .flush(flush), .rs_valid_in(rs_valid_in),
      .rs_opa_in(rs_opa_in), .rs_opb_in(rs_opb_in), .rs_dest_tag_in(rs_dest_tag_in),
      .rs_rob_idx_in(rs_rob_idx_in), .cdb_grant_in(cdb_grant_in),
      .mult_available(mult_available), .result_out(result_out),
      .result_tag_out(result_tag_out), .result_rob_idx_out(result_rob_idx_out),
      .result_valid_out(result_valid_out)
   );

   always #5 clock = ~clock;

   // Reference model: in-order queue of accepted ops, each stamped with its acceptance edge.
   // An op is visible once N edges have passed (acceptance edge included) and all older ops left.
   typedef struct {
      logic [63:0]      prod;
      logic [TAG_W-1:0] tag;
      logic [ROB_W-1:0] rob;
      int               acc;
   } op_t;

   op_t exp_q[$];
   int  edge_cnt = 0;
   int  tests_run = 0;
   int  tests_failed = 0;

   function automatic logic exp_valid();
      return (exp_q.size() > 0) && (edge_cnt >= exp_q[0].acc + N - 1);
   endfunction

   function automatic logic exp_avail();
      return (exp_q.size() < N) || (exp_valid() && cdb_grant_in);
   endfunction

   function automatic logic [63:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   function automatic logic [63:0] pick_opb();
      case ($urandom_range(3))
         0: return 64'hFFFF_FFFF_FFFF_FFFF;
         1: return 64'($urandom_range(255));
         default: return rand64();
      endcase
   endfunction

   task automatic set_inputs(input logic v, input logic [63:0] a, input logic [63:0] b,
                             input logic [TAG_W-1:0] tg, input logic [ROB_W-1:0] rb,
                             input logic g, input logic f);
      rs_valid_in    = v;
      rs_opa_in      = a;
      rs_opb_in      = b;
      rs_dest_tag_in = tg;
      rs_rob_idx_in  = rb;
      cdb_grant_in   = g;
      flush          = f;
   endtask

   // Advance one clock and update the model from the inputs currently driven.
   task automatic tick();
      logic acc, ret, fl;
      op_t  op;
      acc     = rs_valid_in && exp_avail() && !flush;
      ret     = exp_valid() && cdb_grant_in;
      fl      = flush;
      op.prod = rs_opa_in * rs_opb_in;
      op.tag  = rs_dest_tag_in;
      op.rob  = rs_rob_idx_in;
      op.acc  = 0;
      @(posedge clock);
      edge_cnt++;
      if (fl) begin
         exp_q.delete();
      end else begin
         if (ret) void'(exp_q.pop_front());
         if (acc) begin
            op.acc = edge_cnt;
            exp_q.push_back(op);
         end
      end
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_inputs(1'b0, 64'd0, 64'd0, '0, '0, 1'b0, 1'b0);
      #2;
      tests_run++; if (result_valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b want 0", result_valid_out); end
      tests_run++; if (result_out !== 64'd0) begin tests_failed++; $display("FAIL reset_result got %h want 0", result_out); end
      tests_run++; if ({result_tag_out, result_rob_idx_out} !== {(TAG_W+ROB_W){1'b0}}) begin tests_failed++; $display("FAIL reset_tag_rob got %0d/%0d want 0/0", result_tag_out, result_rob_idx_out); end
      tests_run++; if (mult_available !== 1'b1) begin tests_failed++; $display("FAIL reset_avail got %0b want 1", mult_available); end
      @(negedge clock);
      reset = 1'b0;
      #1;
      tests_run++; if (result_valid_out !== 1'b0 || mult_available !== 1'b1) begin tests_failed++; $display("FAIL post_reset got valid=%0b avail=%0b want 0/1", result_valid_out, mult_available); end
   endtask

   task automatic test_single_op();
      set_inputs(1'b1, 64'd32, 64'd26, 6'd1, 5'd0, 1'b1, 1'b0);
      #1;
      tests_run++; if (mult_available !== 1'b1) begin tests_failed++; $display("FAIL single_avail got %0b want 1", mult_available); end
      tick();
      set_inputs(1'b0, 64'd0, 64'd0, '0, '0, 1'b1, 1'b0);
      for (int i = 1; i <= N + 1; i++) begin
         #1;
         tests_run++; if (result_valid_out !== (i == N)) begin tests_failed++; $display("FAIL single_valid cyc%0d got %0b want %0b", i, result_valid_out, (i == N)); end
         tests_run++; if (result_out !== ((i == N) ? 64'h340 : 64'd0)) begin tests_failed++; $display("FAIL single_result cyc%0d got %h", i, result_out); end
         tests_run++; if (result_tag_out !== ((i == N) ? 6'd1 : 6'd0) || result_rob_idx_out !== 5'd0) begin tests_failed++; $display("FAIL single_tag cyc%0d got %0d/%0d", i, result_tag_out, result_rob_idx_out); end
         tick();
      end
   endtask

   task automatic test_wraparound();
      set_inputs(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd2, 5'd3, 1'b1, 1'b0);
      tick();
      set_inputs(1'b1, 64'h1_0000_0000, 64'h1_0000_0000, 6'd3, 5'd4, 1'b1, 1'b0);
      tick();
      set_inputs(1'b0, 64'd0, 64'd0, '0, '0, 1'b1, 1'b0);
      for (int i = 2; i <= N + 2; i++) begin
         #1;
         if (i == N) begin
            tests_run++; if (result_valid_out !== 1'b1 || result_out !== 64'hFFFF_FFFF_FFFF_FFFE || result_tag_out !== 6'd2) begin tests_failed++; $display("FAIL wrap_neg got v=%0b %h tag=%0d want 1 fffffffffffffffe 2", result_valid_out, result_out, result_tag_out); end
         end else if (i == N + 1) begin
            tests_run++; if (result_valid_out !== 1'b1 || result_out !== 64'd0 || result_tag_out !== 6'd3) begin tests_failed++; $display("FAIL wrap_zero got v=%0b %h tag=%0d want 1 0 3", result_valid_out, result_out, result_tag_out); end
         end else begin
            tests_run++; if (result_valid_out !== 1'b0) begin tests_failed++; $display("FAIL wrap_idle cyc%0d got %0b want 0", i, result_valid_out); end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] a [5];
      logic [63:0] b [5];
      for (int j = 0; j < 5; j++) begin
         a[j] = rand64();
         b[j] = pick_opb();
      end
      for (int c = 0; c <= 5 + N; c++) begin
         if (c < 5) set_inputs(1'b1, a[c], b[c], TAG_W'(10 + c), ROB_W'(c), 1'b1, 1'b0);
         else       set_inputs(1'b0, 64'd0, 64'd0, '0, '0, 1'b1, 1'b0);
         #1;
         if (c < 5) begin
            tests_run++; if (mult_available !== 1'b1) begin tests_failed++; $display("FAIL b2b_avail cyc%0d got %0b want 1", c, mult_available); end
         end
         if (c >= N && c - N < 5) begin
            tests_run++; if (result_valid_out !== 1'b1 || result_out !== a[c-N] * b[c-N] || result_rob_idx_out !== ROB_W'(c - N)) begin tests_failed++; $display("FAIL b2b_result op%0d got v=%0b %h rob=%0d want %h", c - N, result_valid_out, result_out, result_rob_idx_out, a[c-N] * b[c-N]); end
         end else begin
            tests_run++; if (result_valid_out !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle cyc%0d got %0b want 0", c, result_valid_out); end
         end
         tick();
      end
   endtask

   task automatic test_stall();
      logic [63:0] p [N];
      logic [63:0] a, b;
      for (int c = 0; c <= N + 3; c++) begin
         a = rand64();
         b = pick_opb();
         if (c < N) p[c] = a * b;
         set_inputs(1'b1, a, b, TAG_W'(20 + c), ROB_W'(c), 1'b0, 1'b0);
         #1;
         tests_run++; if (mult_available !== (c < N)) begin tests_failed++; $display("FAIL stall_avail cyc%0d got %0b want %0b", c, mult_available, (c < N)); end
         if (c >= N) begin
            tests_run++; if (result_valid_out !== 1'b1 || result_out !== p[0] || result_tag_out !== TAG_W'(20)) begin tests_failed++; $display("FAIL stall_hold cyc%0d got v=%0b %h tag=%0d want %h", c, result_valid_out, result_out, result_tag_out, p[0]); end
         end
         tick();
      end
      set_inputs(1'b0, 64'd0, 64'd0, '0, '0, 1'b1, 1'b0);
      for (int c = 0; c <= N; c++) begin
         #1;
         tests_run++; if (result_valid_out !== (c < N) || result_out !== ((c < N) ? p[c] : 64'd0)) begin tests_failed++; $display("FAIL stall_drain cyc%0d got v=%0b %h", c, result_valid_out, result_out); end
         if (c < N) begin
            tests_run++; if (result_tag_out !== TAG_W'(20 + c)) begin tests_failed++; $display("FAIL stall_drain_tag cyc%0d got %0d want %0d", c, result_tag_out, 20 + c); end
         end
         tick();
      end
   endtask

   task automatic test_flush();
      for (int c = 0; c < 3; c++) begin
         set_inputs(1'b1, rand64(), rand64(), TAG_W'(30 + c), ROB_W'(c), 1'b1, 1'b0);
         tick();
      end
      set_inputs(1'b1, rand64(), rand64(), 6'd40, 5'd9, 1'b1, 1'b1);
      tick();
      set_inputs(1'b0, 64'd0, 64'd0, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i <= 2 * N; i++) begin
         #1;
         if (i == 0) begin
            tests_run++; if (mult_available !== 1'b1) begin tests_failed++; $display("FAIL flush_avail got %0b want 1", mult_available); end
         end
         tests_run++; if (result_valid_out !== 1'b0 || result_out !== 64'd0) begin tests_failed++; $display("FAIL flush_result cyc%0d got v=%0b %h want 0", i, result_valid_out, result_out); end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] a, b;
      set_inputs(1'b1, rand64(), rand64(), 6'd5, 5'd6, 1'b0, 1'b0);
      tick();
      set_inputs(1'b1, rand64(), rand64(), 6'd7, 5'd8, 1'b0, 1'b0);
      tick();
      set_inputs(1'b0, 64'd0, 64'd0, '0, '0, 1'b0, 1'b0);
      for (int i = 2; i < N; i++) tick();
      #1;
      tests_run++; if (result_valid_out !== 1'b1) begin tests_failed++; $display("FAIL rmid_inflight got %0b want 1", result_valid_out); end
      #1 reset = 1'b1;
      #1;
      tests_run++; if (result_valid_out !== 1'b0 || result_out !== 64'd0 || result_tag_out !== 6'd0 || mult_available !== 1'b1) begin tests_failed++; $display("FAIL rmid_async got v=%0b %h tag=%0d avail=%0b want 0 0 0 1", result_valid_out, result_out, result_tag_out, mult_available); end
      #1 reset = 1'b0;
      exp_q.delete();
      set_inputs(1'b0, 64'd0, 64'd0, '0, '0, 1'b1, 1'b0);
      tick();
      for (int i = 0; i <= N; i++) begin
         #1;
         tests_run++; if (result_valid_out !== 1'b0) begin tests_failed++; $display("FAIL rmid_ghost cyc%0d got %0b want 0", i, result_valid_out); end
         tick();
      end
      a = rand64();
      b = pick_opb();
      set_inputs(1'b1, a, b, 6'd9, 5'd1, 1'b1, 1'b0);
      tick();
      set_inputs(1'b0, 64'd0, 64'd0, '0, '0, 1'b1, 1'b0);
      for (int i = 1; i <= N; i++) begin
         #1;
         tests_run++; if (result_valid_out !== (i == N) || result_out !== ((i == N) ? a * b : 64'd0)) begin tests_failed++; $display("FAIL rmid_after cyc%0d got v=%0b %h want %h", i, result_valid_out, result_out, a * b); end
         tick();
      end
   endtask

   task automatic test_random();
      logic ev;
      for (int c = 0; c < 400; c++) begin
         set_inputs(($urandom_range(9) < 7), rand64(), pick_opb(), TAG_W'($urandom()),
                    ROB_W'($urandom()), ($urandom_range(9) < 6), ($urandom_range(49) == 0));
         #1;
         ev = exp_valid();
         tests_run++; if (result_valid_out !== ev) begin tests_failed++; $display("FAIL rand_valid cyc%0d got %0b want %0b", c, result_valid_out, ev); end
         tests_run++; if (result_out !== (ev ? exp_q[0].prod : 64'd0)) begin tests_failed++; $display("FAIL rand_result cyc%0d got %h want %h", c, result_out, ev ? exp_q[0].prod : 64'd0); end
         tests_run++; if ({result_tag_out, result_rob_idx_out} !== (ev ? {exp_q[0].tag, exp_q[0].rob} : {(TAG_W+ROB_W){1'b0}})) begin tests_failed++; $display("FAIL rand_tag_rob cyc%0d got %0d/%0d", c, result_tag_out, result_rob_idx_out); end
         tests_run++; if (mult_available !== exp_avail()) begin tests_failed++; $display("FAIL rand_avail cyc%0d got %0b want %0b", c, mult_available, exp_avail()); end
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_op();
      test_wraparound();
      test_back_to_back();
      test_stall();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
